tsensor_sampler: RTL

TSENSOR_SAMPLER -- requirements
Module: tsensor_sampler

---
 rtl/tsensor_pkg.sv | 19 +
 rtl/tsensor_avg_acc.sv | 39 +++
 rtl/tsensor_sampler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tsensor_pkg.sv
// Shared types and default parameter values for the temperature-sensor sampler.
package tsensor_pkg;

    localparam int DATA_W        = 16;
    localparam int EN_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF   = 63;
    localparam int AVG_LOG2_DEF  = 2;

    typedef logic [DATA_W-1:0] tsdata_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/tsensor_avg_acc.sv
// Sample accumulator for the sampler: adds one sample per add strobe and presents
// the truncated average of (accumulator + current sample) for loading on the last add.
module tsensor_avg_acc
    import tsensor_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg_next
);

    // AVG_LOG2 guard bits hold 2^AVG_LOG2 full-scale samples without wrapping.
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;

    function automatic logic [DATA_W-1:0] trunc_avg(input logic [ACC_W-1:0] s);
        return DATA_W'(s >> AVG_LOG2);
    endfunction

    assign sum      = acc_q + ACC_W'(sample);
    assign avg_next = trunc_avg(sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (add) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/tsensor_sampler.sv
// Sequences sensor conversions, averages 2^AVG_LOG2 results and hands them out via valid/ready.
// Optional threshold alarm (i_thresh/o_alarm) is built when TSENSOR_SAMPLER_ALARM_EN is defined.
module tsensor_sampler
    import tsensor_pkg::*;
#(
    parameter int EN_CYCLES = EN_CYCLES_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int AVG_LOG2  = AVG_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              sen_en,
    input  logic              sen_valid,
    input  logic [DATA_W-1:0] sen_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
`ifdef TSENSOR_SAMPLER_ALARM_EN
    input  logic [DATA_W-1:0] i_thresh,
    output logic              o_alarm,
`endif
    output logic              o_err
);

    localparam logic [7:0] EN_LAST  = 8'(EN_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT);
    localparam logic [4:0] SMP_LAST = 5'((1 << AVG_LOG2) - 1);

    state_t            state_q, state_d;
    logic [7:0]        cyc_q;
    logic [4:0]        smp_q;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] avg_next;
    logic              timeout;
    logic              acc_clr;
    logic              load_out;

    always_comb begin
        state_d  = state_q;
        timeout  = 1'b0;
        acc_clr  = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: if (i_start) state_d = ARM;
            ARM:  if (cyc_q == EN_LAST) state_d = WAIT;
            WAIT: begin
                // A strobe in the final wait cycle still counts as a sample.
                if (sen_valid) begin
                    state_d = ACC;
                end else if (cyc_q == TO_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                    acc_clr = 1'b1;
                end
            end
            ACC: begin
                if (smp_q == SMP_LAST) begin
                    state_d  = OUT;
                    load_out = 1'b1;
                end else begin
                    state_d = ARM;
                end
            end
            OUT: begin
                if (i_ready) begin
                    state_d = IDLE;
                    acc_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            smp_q    <= '0;
            sample_q <= '0;
            sen_en   <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == state_q && (state_q == ARM || state_q == WAIT)) begin
                cyc_q <= cyc_q + 8'd1;
            end else begin
                cyc_q <= '0;
            end
            if (acc_clr) begin
                smp_q <= '0;
            end else if (state_q == ACC) begin
                smp_q <= smp_q + 5'd1;
            end
            if (state_q == WAIT && sen_valid) begin
                sample_q <= sen_data;
            end
            sen_en  <= (state_d == ARM);
            o_valid <= (state_d == OUT);
            o_err   <= timeout;
            if (load_out) begin
                o_data <= avg_next;
            end
        end
    end

`ifdef TSENSOR_SAMPLER_ALARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_alarm <= 1'b0;
        end else if (load_out) begin
            o_alarm <= (avg_next > i_thresh);
        end
    end
`endif

    assign o_busy = (state_q != IDLE);

    tsensor_avg_acc #(
        .AVG_LOG2(AVG_LOG2)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .add     (state_q == ACC),
        .sample  (sample_q),
        .avg_next(avg_next)
    );

endmodule
